vga_fb_scheduler: RTL and testbench

VGA_FB_SCHEDULER -- requirements
Module: vga_fb_scheduler

---
 rtl/vga_fb_scheduler.sv | 143 ++++++++++++++
 tb/tb_vga_fb_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_scheduler.sv
`timescale 1ns/1ps
// Purpose: arbitrates one single-port framebuffer between VGA display reads and a writer port.
// Latency: pixel appears 2 clocks after its CounterX; a granted write strobes 1 clock after grant, wr_ack 1 clock later.
// Backpressure: display reads always win; a writer holds wr_req until the wr_ack pulse.
//
// Ports:
//   clk, rst            pixel clock, async active-high reset
//   CounterX/CounterY   timing generator counts (800 x 521 total)
//   wr_req/wr_x/wr_y/wr_data -> wr_ack (pulse), wr_err (sticky out-of-range)
//   mem_addr/mem_we/mem_wdata -> framebuffer, mem_rdata <- framebuffer (1-cycle read)
//   pixel               registered pixel to the DAC
//
// Build option: define FB_BLANK_WRITE_EN to restrict write grants to lines CounterY >= 480.
module vga_fb_scheduler #(
    parameter int ADDR_W = 15,
    parameter int PIX_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        CounterX,
    input  logic [9:0]        CounterY,
    input  logic              wr_req,
    input  logic [7:0]        wr_x,
    input  logic [6:0]        wr_y,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  pixel
);

    localparam logic [9:0] H_LAST   = 10'd799;
    localparam logic [9:0] V_LAST   = 10'd520;
    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] V_ACTIVE = 10'd480;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DISP_RD = 2'd1,
        CPU_WR  = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t state;

    // Outputs are registered, so every decision is made one cycle ahead
    // using the counter values the timing generator will present next.
    logic [9:0] nx;
    logic [9:0] ny;

    always_comb begin
        nx = CounterX + 10'd1;
        ny = CounterY;
        if (CounterX >= H_LAST) begin
            nx = 10'd0;
            ny = (CounterY >= V_LAST) ? 10'd0 : CounterY + 10'd1;
        end
    end

    logic slot_next;
    logic act_cur;
    logic wr_ok;
    logic blank_ok;
    logic [ADDR_W-1:0] disp_addr;
    logic [ADDR_W-1:0] wr_addr;

    assign slot_next = (nx < H_ACTIVE) && (ny < V_ACTIVE) && (nx[1:0] == 2'b00);
    assign act_cur   = (CounterX < H_ACTIVE) && (CounterY < V_ACTIVE);
    assign wr_ok     = (wr_x < 8'd160) && (wr_y < 7'd120);
    assign disp_addr = ADDR_W'(ny[9:2]) * ADDR_W'(160) + ADDR_W'(nx[9:2]);
    assign wr_addr   = ADDR_W'(wr_y) * ADDR_W'(160) + ADDR_W'(wr_x);

`ifdef FB_BLANK_WRITE_EN
    // Tear-free mode: the write itself must land in a vertical-blank line.
    assign blank_ok = (ny >= V_ACTIVE);
`else
    assign blank_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wr_ack    <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            // The ack follows CPU_WR even if a display slot pre-empts ACK,
            // so the writer is never left waiting.
            wr_ack <= (state == CPU_WR);
            if (slot_next) begin
                state    <= DISP_RD;
                mem_addr <= disp_addr;
            end else begin
                case (state)
                    IDLE: begin
                        // Grants only from IDLE: ACK and DISP_RD both return
                        // here first, so a just-acked request is never re-granted.
                        if (wr_req && blank_ok) begin
                            state <= CPU_WR;
                            if (wr_ok) begin
                                mem_we    <= 1'b1;
                                mem_addr  <= wr_addr;
                                mem_wdata <= wr_data;
                            end else begin
                                wr_err <= 1'b1;
                            end
                        end
                    end
                    CPU_WR:  state <= ACK;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Read data returns the cycle after DISP_RD; capture it then and hold
    // for the 4-clock group. Blanking zeroes the pixel on the same 2-clock lag.
    logic rd_pend;
    logic act_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
            act_d   <= 1'b0;
            pixel   <= '0;
        end else begin
            rd_pend <= (state == DISP_RD);
            act_d   <= act_cur;
            if (rd_pend) begin
                pixel <= mem_rdata;
            end else if (!act_d) begin
                pixel <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
`timescale 1ns/1ps
// Purpose: randomized self-checking bench for vga_fb_scheduler with a framebuffer model.
// Latency: expects pixel 2 clocks after CounterX, write strobe then wr_ack on consecutive cycles.
// Backpressure: writer holds each request until wr_ack, then idles a random gap.
module tb_vga_fb_scheduler;

    localparam int ADDR_W = 15;
    localparam int PIX_W  = 3;
    localparam int NCYC   = 70000;
`ifdef FB_BLANK_WRITE_EN
    localparam int BOUND  = 8000;
`else
    localparam int BOUND  = 20;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [9:0]        cx;
    logic [9:0]        cy;
    logic              wr_req;
    logic [7:0]        wr_x;
    logic [6:0]        wr_y;
    logic [PIX_W-1:0]  wr_data;
    logic              wr_ack;
    logic              wr_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [PIX_W-1:0]  mem_wdata;
    logic [PIX_W-1:0]  mem_rdata;
    logic [PIX_W-1:0]  pixel;

    logic [PIX_W-1:0]  ram [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    vga_fb_scheduler #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .CounterX (cx),
        .CounterY (cy),
        .wr_req   (wr_req),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .wr_err   (wr_err),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .pixel    (pixel)
    );

    // Synchronous single-port framebuffer, preloaded with addr mod 8 while in reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= PIX_W'(i % 8);
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, want, $time);
        end
    endtask

    initial begin
        int x, y, k;
        int held, ep1, ep2, exp_pix, prev_addr;
        int rq_x, rq_y, rq_d, rq_age, nwrites, last_we_k, last_addr, last_data, gap;
        int since_rst, rst_cnt, chk39_k, d40_acks, d42_acks;
        bit pend, slot, act, settled, valid, err_model;
        bit is40, is42, dir40_done, dir42_done, rst_done;

        held = 0; ep1 = 0; ep2 = 0; prev_addr = 0;
        rq_x = 0; rq_y = 0; rq_d = 0; rq_age = 0; nwrites = 0;
        last_we_k = -10; last_addr = 0; last_data = 0; gap = 0;
        since_rst = 0; chk39_k = -1; d40_acks = 0; d42_acks = 0;
        pend = 0; err_model = 0; is40 = 0; is42 = 0;
        dir40_done = 0; dir42_done = 0; rst_done = 0;

        rst = 1'b1;
        cx = 10'd798; cy = 10'd520;
        wr_req = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
        #1;
        check("rst_pixel", pixel, 0);
        check("rst_ack", wr_ack, 0);
        check("rst_err", wr_err, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        repeat (3) @(posedge clk);
        rst_cnt = 1;

        for (k = 0; k < NCYC; k++) begin
            @(negedge clk);
            // Abbreviated frame: lines 0..7 then 478..520, horizontal blank
            // shortened by jumping 645 -> 796 (never crosses a display slot).
            if (cx == 10'd645) begin
                x = 796;
                y = (cy == 10'd7) ? 478 : int'(cy);
            end else if (cx == 10'd799) begin
                x = 0;
                y = (cy == 10'd520) ? 0 : int'(cy) + 1;
            end else begin
                x = int'(cx) + 1;
                y = int'(cy);
            end

            if (rst) begin
                check("rst_no_ack", wr_ack, 0);
                if (rst_cnt > 0) rst_cnt--;
                if (rst_cnt == 0) begin
                    rst = 1'b0;
                    since_rst = 0;
                end
            end else begin
                since_rst++;
            end

            slot    = (x < 640) && (y < 480) && (x % 4 == 0);
            act     = (x < 640) && (y < 480);
            settled = !rst && (since_rst >= 10);

            // Pixel model: value read at the group's slot, shown 2 clocks later.
            exp_pix = ep1;
            ep1 = ep2;
            if (slot) held = int'(ram[(y / 4) * 160 + x / 4]);
            ep2 = act ? held : 0;

            if (settled) check("pixel", pixel, exp_pix);
            if (k == chk39_k) check("pix_x8_y4", pixel, 2);
            if (x == 8 && y == 4 && chk39_k < 0 && k < 3000) chk39_k = k + 2;

            if (settled && slot) begin
                check("slot_we", mem_we, 0);
                check("slot_addr", mem_addr, (y / 4) * 160 + x / 4);
            end
            if (!rst && mem_we) begin
                check("we_pending", pend, 1);
                check("we_addr", mem_addr, rq_y * 160 + rq_x);
                check("we_data", mem_wdata, rq_d);
`ifdef FB_BLANK_WRITE_EN
                check("we_blank", y >= 480, 1);
`endif
                nwrites++;
                last_we_k = k;
                last_addr = int'(mem_addr);
                last_data = int'(mem_wdata);
            end else if (settled && !slot) begin
                check("idle_addr", mem_addr, prev_addr);
            end
            prev_addr = int'(mem_addr);

            if (!rst && wr_ack) begin
                valid = (rq_x < 160) && (rq_y < 120);
                check("ack_pending", pend, 1);
                check("ack_writes", nwrites, valid);
                if (valid) check("ack_latency", k - last_we_k, 1);
                else err_model = 1;
                check("err_flag", wr_err, err_model);
                if (is40) begin
                    check("d40_addr", last_addr, 485);
                    check("d40_data", last_data, 7);
                    d40_acks++;
                end
                if (is42) begin
                    check("d42_no_we", nwrites, 0);
                    check("d42_err", wr_err, 1);
                    d42_acks++;
                end
                pend = 0; is40 = 0; is42 = 0;
                gap = $urandom_range(0, 5);
            end else if (pend) begin
                rq_age++;
                if (rq_age > BOUND) begin
                    check("ack_timeout", rq_age, BOUND);
                    pend = 0; is40 = 0; is42 = 0;
                end
            end

            // Asynchronous reset in the middle of a write strobe.
            if (!rst && !rst_done && k > 40000 && mem_we) begin
                rst = 1'b1;
                #1;
                check("arst_we", mem_we, 0);
                check("arst_pixel", pixel, 0);
                check("arst_ack", wr_ack, 0);
                check("arst_addr", mem_addr, 0);
                check("arst_err", wr_err, 0);
                rst_done = 1; rst_cnt = 3;
                nwrites = 0; err_model = 0; rq_age = 0;
            end

            if (!pend) begin
                if (k < 3000 || gap > 0) begin
                    if (gap > 0) gap--;
                end else begin
                    is40 = !dir40_done && y >= 500 && y < 520;
                    is42 = !is40 && dir40_done && !dir42_done && k > 22000;
                    if (is40) begin
                        rq_x = 5; rq_y = 3; rq_d = 7; dir40_done = 1;
                    end else if (is42) begin
                        rq_x = 160; rq_y = $urandom_range(0, 119);
                        rq_d = $urandom_range(0, 7); dir42_done = 1;
                    end else begin
                        rq_x = $urandom_range(0, 159);
                        rq_y = $urandom_range(0, 119);
                        rq_d = $urandom_range(0, 7);
                        if (k > 20000 && $urandom_range(0, 15) == 0) begin
                            if ($urandom_range(0, 1) == 1) rq_x = $urandom_range(160, 255);
                            else rq_y = $urandom_range(120, 127);
                        end
                    end
                    pend = 1; rq_age = 0; nwrites = 0;
                end
            end

            wr_req = pend;
            if (pend) begin
                wr_x = 8'(rq_x); wr_y = 7'(rq_y); wr_data = PIX_W'(rq_d);
            end else begin
                wr_x = 8'($urandom); wr_y = 7'($urandom); wr_data = PIX_W'($urandom);
            end
            cx = 10'(x);
            cy = 10'(y);
        end

        check("d40_acked", d40_acks, 1);
        check("d42_acked", d42_acks, 1);
        check("mid_reset_hit", rst_done, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
